// File: rtl/debounce_onepulse.sv
// Purpose: push-button conditioner (two-flop sync, tick-sampled N-of-N filter, rising-edge strobe).
// Latency: pb_db follows a stable pb_in edge in 2+(N-1)*DIV+1 .. 2+N*DIV cycles; pulse coincides with pb_db rising.
// Backpressure: none; pulse is a one-cycle strobe the consumer must accept when it fires.
module debounce_onepulse #(
  parameter int DIV = 4,
  parameter int N   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  output logic pb_db,
  output logic pulse
);

  // Prescaler must reach DIV-1; stability counter must reach N-1.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(DIV - 1);
  localparam logic [CW-1:0] ST_MAX = CW'(N - 1);

  logic          pb_meta;
  logic          pb_s;
  logic [PW-1:0] ps_cnt;
  logic          tick;
  logic [CW-1:0] st_cnt;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pb_meta <= 1'b0;
      pb_s    <= 1'b0;
    end else begin
      pb_meta <= pb_in;
      pb_s    <= pb_meta;
    end
  end

  // Sample tick on the last count of the prescaler; with DIV=1 it is always high.
  assign tick = (ps_cnt == PS_MAX);

  // Prescaler counts 0..DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PW'(1);
    end
  end

  // Filter: N consecutive differing tick samples flip pb_db; a rising flip raises pulse for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_cnt <= '0;
      pb_db  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (tick) begin
        if (pb_s == pb_db) begin
          st_cnt <= '0;
        end else if (st_cnt == ST_MAX) begin
          pb_db  <= ~pb_db;
          st_cnt <= '0;
          pulse  <= ~pb_db;
        end else begin
          st_cnt <= st_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_onepulse.sv
// Purpose: scoreboard bench for debounce_onepulse at DIV=4, N=4.
// Latency: expected pb_db edges carry a cycle window; pulses must coincide with a pb_db rise.
// Backpressure: none; monitor consumes every DUT event as it appears.
module tb_debounce_onepulse;

  localparam int K_RISE  = 0;
  localparam int K_FALL  = 1;
  localparam int K_PULSE = 2;

  typedef struct {
    int kind;
    int lo;
    int hi;
  } exp_t;

  logic clk;
  logic rst;
  logic pb_in;
  logic pb_db;
  logic pulse;

  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;
  logic prev_db;
  exp_t sb[$];

  debounce_onepulse #(.DIV(4), .N(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .pb_in (pb_in),
    .pb_db (pb_db),
    .pulse (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so stimulus and monitor share a time base.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pb_db change and every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (mon_en) begin
      if (pb_db !== prev_db) begin
        k = pb_db ? K_RISE : K_FALL;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL edge: pb_db went to %0b at cycle %0d, nothing expected", pb_db, cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind != k || cyc < e.lo || cyc > e.hi) begin
            errors++;
            $display("FAIL edge: got kind %0d at cycle %0d, expected kind %0d in %0d..%0d",
                     k, cyc, e.kind, e.lo, e.hi);
          end
        end
      end
      if (pulse === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pulse: pulse at cycle %0d, nothing expected", cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind != K_PULSE || !(prev_db === 1'b0 && pb_db === 1'b1)) begin
            errors++;
            $display("FAIL pulse: at cycle %0d head kind %0d pb_db %0b->%0b, expected kind %0d on a 0->1 rise",
                     cyc, e.kind, prev_db, pb_db, K_PULSE);
          end
        end
      end
      if (sb.size() != 0 && cyc > sb[0].hi) begin
        checks++;
        errors++;
        $display("FAIL late: kind %0d not seen by cycle %0d (cycle now %0d)", sb[0].kind, sb[0].hi, cyc);
        void'(sb.pop_front());
      end
      prev_db = pb_db;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int lo, input int hi);
    exp_t e;
    e.kind = kind;
    e.lo   = lo;
    e.hi   = hi;
    sb.push_back(e);
  endtask

  // Expect a clean press edge launched at cycle t0: rise in 15..18 cycles plus one pulse.
  task automatic expect_press(input int t0);
    push(K_RISE, t0 + 15, t0 + 18);
    push(K_PULSE, t0 + 15, t0 + 18);
  endtask

  task automatic check_low(input string name);
    checks++;
    if (pb_db !== 1'b0 || pulse !== 1'b0) begin
      errors++;
      $display("FAIL %s: pb_db=%0b pulse=%0b, required 0 and 0", name, pb_db, pulse);
    end
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int t0;
    cyc     = 0;
    checks  = 0;
    errors  = 0;
    mon_en  = 1'b0;
    prev_db = 1'b0;
    rst     = 1'b1;
    pb_in   = 1'b1;

    // Reset held 3 cycles with the button pressed.
    step(1);
    mon_en = 1'b1;
    check_low("reset_c1");
    step(1);
    check_low("reset_c2");
    step(1);
    check_low("reset_c3");
    rst = 1'b0;
    t0  = cyc;
    expect_press(t0);
    step(1);
    check_low("post_reset_c1");
    drain("press_after_reset", 60);
    step(10);

    // Release.
    pb_in = 1'b0;
    push(K_FALL, cyc + 15, cyc + 18);
    drain("release_1", 60);
    step(30);

    // Clean press held 40 cycles.
    pb_in = 1'b1;
    expect_press(cyc);
    step(40);
    drain("clean_press", 20);

    // Release then re-press 30 cycles later.
    pb_in = 1'b0;
    t0    = cyc;
    push(K_FALL, t0 + 15, t0 + 18);
    step(30);
    drain("release_2", 20);
    pb_in = 1'b1;
    expect_press(cyc);
    step(40);
    drain("second_press", 20);

    // Reset mid-press: pb_db drops on the first reset edge.
    rst = 1'b1;
    push(K_FALL, cyc + 1, cyc + 1);
    step(1);
    check_low("midpress_rst_c1");
    step(1);
    check_low("midpress_rst_c2");
    rst = 1'b0;
    expect_press(cyc);
    step(40);
    drain("press_after_midreset", 20);

    // Release back to idle.
    pb_in = 1'b0;
    push(K_FALL, cyc + 15, cyc + 18);
    drain("release_3", 60);
    step(20);

    // Glitch: 3 cycles high while idle produces nothing.
    pb_in = 1'b1;
    step(3);
    pb_in = 1'b0;
    step(40);
    check_low("glitch");
    drain("glitch_quiet", 1);

    // Bounce: toggle every 3 cycles for 24 cycles, then hold high.
    t0 = cyc;
    push(K_RISE, t0 + 1, t0 + 24 + 18);
    push(K_PULSE, t0 + 1, t0 + 24 + 18);
    for (int s = 0; s < 8; s++) begin
      pb_in = (s % 2 == 0) ? 1'b1 : 1'b0;
      step(3);
    end
    pb_in = 1'b1;
    step(40);
    drain("bounce", 20);
    checks++;
    if (pb_db !== 1'b1) begin
      errors++;
      $display("FAIL bounce_hold: pb_db=%0b, required 1", pb_db);
    end

    // Final release.
    pb_in = 1'b0;
    push(K_FALL, cyc + 15, cyc + 18);
    drain("release_4", 60);
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_onepulse.md
DEBOUNCE_ONEPULSE -- requirements
Module: debounce_onepulse

Interface
REQ-001 The block SHALL have the parameter DIV, default 4, meaning clock cycles per debounce sample tick (legal range DIV >= 1).
REQ-002 The block SHALL have the parameter N, default 4, meaning consecutive differing samples needed to change the debounced level (legal range N >= 2).
REQ-003 The block SHALL have the port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have the port pb_in  input  1  raw push-button level, asynchronous to clk and possibly bouncing.
REQ-006 The block SHALL have the port pb_db  output  1  debounced, registered button level.
REQ-007 The block SHALL have the port pulse  output  1  single-cycle press strobe, intended to drive the `in` input of the add/sub mode toggle FSM.

Function
REQ-008 pb_in SHALL pass through a two-flop synchronizer; only the second flop output (pb_s) is used internally.
REQ-009 A prescaler SHALL count 0..DIV-1 and wrap to 0.
- tick is asserted for exactly one cycle when the count equals DIV-1.
- With DIV=1, tick is asserted every cycle.
REQ-010 On each tick, the block SHALL compare pb_s with pb_db.
- Equal: the stability counter clears to 0.
- Different and counter < N-1: the counter increments.
- Different and counter = N-1: pb_db inverts and the counter clears to 0.
REQ-011 Between ticks, the stability counter and pb_db SHALL hold their values.
REQ-012 Any single tick sample equal to pb_db SHALL restart the filter, so pb_db changes only after N consecutive differing tick samples.
REQ-013 pulse SHALL be asserted in exactly the one cycle in which pb_db first reads 1 after a 0->1 transition.
- pulse is registered, with no combinational path from pb_in.
REQ-014 A 1->0 transition of pb_db SHALL NOT assert pulse.
- Holding the button produces no further pulses.
- Successive presses each produce exactly one pulse.
REQ-015 Latency from a stable pb_in edge to the pb_db change SHALL lie between 2+(N-1)*DIV+1 and 2+N*DIV cycles inclusive, which is 15..18 cycles at the defaults.
REQ-016 The counter and prescaler widths SHALL hold their maximum values with no overflow or wrap-around other than the defined prescaler wrap.
REQ-017 If pb_in changes on the same edge as a tick, that tick SHALL use the pre-change pb_s value, since it has synchronizer delay.

Reset
REQ-018 While rst=1 at a clk edge, the block SHALL clear both synchronizer flops, the prescaler, and the stability counter to 0, and drive pb_db=0 and pulse=0.
REQ-019 Reset SHALL take priority over a tick occurring on the same edge.
REQ-020 Reset asserted mid-press or mid-filter SHALL abandon the filter state with no partial pulse.
- If pb_in remains 1 after reset release, pb_db rises after the REQ-015 latency and exactly one pulse is issued.
REQ-021 The first prescaler tick after reset release SHALL occur DIV cycles after release.

Verification (DIV=4, N=4)
REQ-022 Reset: rst=1 for 3 cycles with pb_in=1 -> pb_db=0 and pulse=0 throughout reset and on the first cycle after release.
REQ-023 Clean press: pb_in 0->1, held 40 cycles -> pb_db rises 15..18 cycles after the edge; pulse=1 for exactly 1 cycle; no further pulse.
REQ-024 Bounce: pb_in toggles every 3 cycles for 24 cycles, then is held at 1 -> exactly one pulse total; pb_db never returns to 0 while pb_in stays 1.
REQ-025 Glitch: a 3-cycle high on pb_in while idle, then 0 -> pb_db stays 0; pulse never asserts.
REQ-026 Release and re-press: after a press, pb_in 1->0 -> pb_db falls 15..18 cycles later with no pulse; a second press 30 cycles later -> second single pulse.
REQ-027 Reset mid-press: pb_db=1 with pb_in held 1, rst=1 for 2 cycles -> pb_db=0 during reset; after release pb_db rises in 15..18 cycles with exactly one pulse.
